// File: rtl/decoder_m2n_scan.sv
// decoder_m2n_scan: M-to-N one-hot decoder with a direct mode and a timed
// channel-scan mode. All outputs are registered.
// Optional build macro DECODER_ACTIVE_LOW_EN: y becomes one-cold
// (inactive/reset value all ones); FSM, idx, busy and done are unaffected.
module decoder_m2n_scan #(
   parameter int M = 2,
   parameter int DWELL = 4,
   localparam int N = 2 ** M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic [M-1:0] a,
   input  logic         start,
   input  logic         stop,
   input  logic         cont,
   output logic [N-1:0] y,
   output logic [M-1:0] idx,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(DWELL + 1);

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic Y_INV = 1'b1;
`else
   localparam logic Y_INV = 1'b0;
`endif

   // XOR mask that flips the active-high pattern into the output polarity
   localparam logic [N-1:0] Y_OFF      = {N{Y_INV}};
   localparam logic [N-1:0] ONE        = N'(1);
   localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL - 1);
   localparam logic [M-1:0] LAST_IDX   = M'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      DIRECT,
      SCAN
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  y_q, y_d;
   logic [M-1:0]  idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  idx_inc;

   assign idx_inc = idx_q + 1'b1;

   // Next-state logic: en has priority, then per-state decode/scan behaviour
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = IDLE;
         y_d     = Y_OFF;
         idx_d   = '0;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               y_d = Y_OFF;
               if (!mode) begin
                  state_d = DIRECT;
                  y_d     = (ONE << a) ^ Y_OFF;
                  idx_d   = a;
               end else if (start) begin
                  state_d = SCAN;
                  y_d     = (ONE << a) ^ Y_OFF;
                  idx_d   = a;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end
            end
            DIRECT: begin
               if (mode) begin
                  state_d = IDLE;
                  y_d     = Y_OFF;
               end else begin
                  y_d   = (ONE << a) ^ Y_OFF;
                  idx_d = a;
               end
            end
            SCAN: begin
               if (stop || !mode) begin
                  state_d = IDLE;
                  y_d     = Y_OFF;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end else if (cnt_q == LAST_DWELL) begin
                  cnt_d = '0;
                  if (idx_q == LAST_IDX) begin
                     if (cont) begin
                        idx_d = '0;
                        y_d   = ONE ^ Y_OFF;
                     end else begin
                        state_d = IDLE;
                        y_d     = Y_OFF;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     idx_d = idx_inc;
                     y_d   = (ONE << idx_inc) ^ Y_OFF;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               y_d     = Y_OFF;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset to the idle pattern
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= Y_OFF;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_decoder_m2n_scan.sv
// Testbench for decoder_m2n_scan: two instances (DWELL=4 and DWELL=1) share
// one stimulus stream and are compared every cycle against a scan-time model.
module tb_decoder_m2n_scan;

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic YINV = 1'b1;
`else
   localparam logic YINV = 1'b0;
`endif
   localparam logic [3:0] YOFF = {4{YINV}};
   localparam int S_IDLE = 0;
   localparam int S_DIRECT = 1;
   localparam int S_SCAN = 2;

   logic clk = 1'b0;
   logic rst, en, mode, start, stop, cont;
   logic [1:0] a;
   logic [3:0] y4, y1;
   logic [1:0] idx4, idx1;
   logic busy4, busy1, done4, done1;

   int n_checks = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   typedef struct {
      int st;
      int ch;
      int base;
      int elapsed;
      bit done;
   } model_t;

   model_t m4, m1;

   always #5 clk = ~clk;

   decoder_m2n_scan #(.M(2), .DWELL(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .start(start),
      .stop(stop), .cont(cont), .y(y4), .idx(idx4), .busy(busy4), .done(done4)
   );

   decoder_m2n_scan #(.M(2), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .start(start),
      .stop(stop), .cont(cont), .y(y1), .idx(idx1), .busy(busy1), .done(done1)
   );

   // Scan position is derived from elapsed time since the scan (or last wrap)
   // began: channel = base + elapsed/dwell, ending after (N-base)*dwell cycles.
   function automatic model_t modelStep(model_t s, int dw, bit r, bit e, bit md,
                                        int av, bit sr, bit sp, bit ct);
      model_t n;
      n = s;
      n.done = 1'b0;
      if (r || !e) begin
         n.st = S_IDLE;
         n.ch = 0;
         return n;
      end
      case (s.st)
         S_IDLE: begin
            if (!md) begin
               n.st = S_DIRECT;
               n.ch = av;
            end else if (sr) begin
               n.st = S_SCAN;
               n.base = av;
               n.elapsed = 0;
               n.ch = av;
            end
         end
         S_DIRECT: begin
            if (md) n.st = S_IDLE;
            else n.ch = av;
         end
         default: begin
            if (sp || !md) begin
               n.st = S_IDLE;
            end else begin
               n.elapsed = s.elapsed + 1;
               if (n.elapsed == (4 - s.base) * dw) begin
                  if (ct) begin
                     n.base = 0;
                     n.elapsed = 0;
                     n.ch = 0;
                  end else begin
                     n.st = S_IDLE;
                     n.done = 1'b1;
                  end
               end else begin
                  n.ch = s.base + n.elapsed / dw;
               end
            end
         end
      endcase
      return n;
   endfunction

   function automatic logic [3:0] oh(int k);
      return 4'(1 << k) ^ YOFF;
   endfunction

   function automatic logic [3:0] expY(model_t s);
      if (s.st == S_IDLE) return YOFF;
      return oh(s.ch);
   endfunction

   // Advance both models on every rising edge using the inputs the DUTs sample
   always @(posedge clk) begin
      m4 = modelStep(m4, 4, rst, en, mode, int'(a), start, stop, cont);
      m1 = modelStep(m1, 1, rst, en, mode, int'(a), start, stop, cont);
   end

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic checkModel();
      checkOutput("y4_model", y4, expY(m4));
      checkOutput("idx4_model", idx4, m4.ch[1:0]);
      checkOutput("busy4_model", busy4, m4.st == S_SCAN);
      checkOutput("done4_model", done4, m4.done);
      checkOutput("y4_onehot0", $onehot0(y4 ^ YOFF), 1);
      checkOutput("y1_model", y1, expY(m1));
      checkOutput("idx1_model", idx1, m1.ch[1:0]);
      checkOutput("busy1_model", busy1, m1.st == S_SCAN);
      checkOutput("done1_model", done1, m1.done);
      checkOutput("y1_onehot0", $onehot0(y1 ^ YOFF), 1);
   endtask

   // Per-cycle comparison on the falling edge, away from the sampling edge
   always @(negedge clk) begin
      if (checking) checkModel();
   end

   task automatic applyStimulus(input bit r, input bit e, input bit md, input int av,
                                input bit sr, input bit sp, input bit ct);
      rst = r;
      en = e;
      mode = md;
      a = 2'(av);
      start = sr;
      stop = sp;
      cont = ct;
      @(posedge clk);
      #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      logic [3:0] prev_y;
      bit md, ct;
      m4 = '{S_IDLE, 0, 0, 0, 1'b0};
      m1 = '{S_IDLE, 0, 0, 0, 1'b0};
      rst = 1'b1; en = 1'b0; mode = 1'b0; a = 2'd0;
      start = 1'b0; stop = 1'b0; cont = 1'b0;
      @(posedge clk);
      #1;
      checking = 1'b1;
      applyStimulus(1, 1, 1, 2, 1, 0, 1);
      checkOutput("reset_y", y4, YOFF);
      checkOutput("reset_idx", idx4, 0);
      checkOutput("reset_busy", busy4, 0);
      checkOutput("reset_done", done4, 0);

      // Direct decode of every select value, then disable
      for (int av = 0; av < 4; av++) begin
         for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 1, 0, av, 0, 0, 0);
            if (c == 0) checkOutput("direct_y", y4, oh(av));
         end
      end
      applyStimulus(0, 0, 0, 3, 0, 0, 0);
      checkOutput("direct_en0_y", y4, YOFF);

      // Single non-continuous scan from channel 1
      applyStimulus(0, 1, 1, 1, 1, 0, 0);
      checkOutput("scan1_y", y4, oh(1));
      checkOutput("scan1_busy", busy4, 1);
      for (int i = 1; i < 12; i++) begin
         applyStimulus(0, 1, 1, 1, 0, 0, 0);
         checkOutput("scan1_y", y4, oh(1 + i / 4));
         checkOutput("scan1_busy", busy4, 1);
      end
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      checkOutput("scan1_end_y", y4, YOFF);
      checkOutput("scan1_end_done", done4, 1);
      checkOutput("scan1_end_busy", busy4, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      checkOutput("scan1_done_clear", done4, 0);

      // Continuous scan from channel 3, then release cont
      applyStimulus(0, 1, 1, 3, 1, 0, 1);
      checkOutput("cont_y", y4, oh(3));
      for (int i = 1; i < 12; i++) begin
         applyStimulus(0, 1, 1, 3, 0, 0, 1);
         checkOutput("cont_y", y4, oh((3 + i / 4) % 4));
         checkOutput("cont_done", done4, 0);
      end
      found = 1'b0;
      prev_y = y4;
      for (int i = 0; i < 40 && !found; i++) begin
         prev_y = y4;
         applyStimulus(0, 1, 1, 3, 0, 0, 0);
         if (done4) found = 1'b1;
      end
      checkOutput("cont_done_seen", found, 1);
      checkOutput("cont_last_channel", prev_y, oh(3));
      checkOutput("cont_end_y", y4, YOFF);

      // Stop on the final dwell cycle of channel 3 suppresses done
      applyStimulus(0, 0, 1, 3, 0, 0, 0);
      applyStimulus(0, 1, 1, 3, 1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 3, 0, 0, 0);
      applyStimulus(0, 1, 1, 3, 0, 1, 0);
      checkOutput("stop_y", y4, YOFF);
      checkOutput("stop_done", done4, 0);
      checkOutput("stop_busy", busy4, 0);
      applyStimulus(0, 1, 1, 3, 0, 0, 0);
      checkOutput("stop_done_after", done4, 0);

      // Same again with reset in place of stop
      applyStimulus(0, 1, 1, 3, 1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 3, 0, 0, 0);
      applyStimulus(1, 1, 1, 3, 0, 0, 0);
      checkOutput("rst_y", y4, YOFF);
      checkOutput("rst_done", done4, 0);
      checkOutput("rst_idx", idx4, 0);
      applyStimulus(0, 1, 1, 3, 0, 0, 0);
      checkOutput("rst_done_after", done4, 0);

      // DWELL=1 scan from channel 0 with a start pulse mid-scan
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 1, 0, 0);
      checkOutput("d1_y", y1, oh(0));
      for (int i = 1; i < 4; i++) begin
         applyStimulus(0, 1, 1, 0, i == 2, 0, 0);
         checkOutput("d1_y", y1, oh(i));
         checkOutput("d1_busy", busy1, 1);
      end
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      checkOutput("d1_done", done1, 1);
      checkOutput("d1_end_y", y1, YOFF);

      // Randomized traffic with sticky mode/cont and occasional disruptions
      $display("[TB] starting randomized phase");
      md = 1'b1;
      ct = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) md = !md;
         if ($urandom_range(0, 9) == 0) ct = !ct;
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) != 0, md,
                       int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                       $urandom_range(0, 39) == 0, ct);
      end

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_m2n_scan.md
DECODER_M2N_SCAN -- requirements
Module: decoder_m2n_scan

Interface
REQ-001 SHALL have parameter M, default 2, select width.
REQ-002 SHALL have localparam N = 2**M, default 4, output width.
REQ-003 SHALL have parameter DWELL, default 4, cycles per channel in scan; legal range 1..65535.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port en  in  1  enable; 0 forces idle with outputs cleared.
REQ-007 SHALL have port mode  in  1  0 = direct decode, 1 = scan.
REQ-008 SHALL have port a  in  M  direct-mode select and scan start channel.
REQ-009 SHALL have port start  in  1  single-cycle scan request.
REQ-010 SHALL have port stop  in  1  single-cycle scan abort.
REQ-011 SHALL have port cont  in  1  1 = scan wraps N-1 -> 0 forever; sampled at each wrap point.
REQ-012 SHALL have port y  out  N  registered one-hot output.
REQ-013 SHALL have port idx  out  M  channel currently driven.
REQ-014 SHALL have port busy  out  1  high while in SCAN.
REQ-015 SHALL have port done  out  1  one-cycle pulse at end of a non-continuous scan.

Function
REQ-016 SHALL implement FSM states IDLE, DIRECT, SCAN; all outputs registered.
REQ-017 en=0 SHALL move to IDLE next edge from any state; en outranks mode, start, stop.
REQ-018 IDLE: y=0, busy=0; en=1 & mode=0 -> DIRECT; en=1 & mode=1 & start=1 -> SCAN with idx<=a, dwell counter<=0.
REQ-019 DIRECT: y SHALL equal one-hot(a) with 1-cycle latency; idx<=a; mode=1 -> IDLE next edge (y=0).
REQ-020 SCAN: y SHALL equal one-hot(idx); idx SHALL hold for exactly DWELL cycles, then increment.
REQ-021 On last dwell cycle of idx=N-1: cont=1 -> idx<=0, remain SCAN; cont=0 -> IDLE, y<=0, done=1 for one cycle.
REQ-022 stop=1 in SCAN SHALL go IDLE next edge, y<=0, no done pulse; stop wins over simultaneous end-of-scan.
REQ-023 start while in SCAN SHALL be ignored (no restart); start in DIRECT ignored.
REQ-024 mode change to 0 during SCAN SHALL abort exactly as stop (no done).
REQ-025 Scan starting at a=k non-continuous SHALL last (N-k)*DWELL cycles of busy=1.
REQ-026 Dwell counter width SHALL be clog2(DWELL+1); DWELL=1 advances idx every cycle.
REQ-027 y SHALL never have more than one bit set in any cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, y=0, idx=0, busy=0, done=0, dwell counter=0.
REQ-029 rst SHALL override en, start and stop; reset mid-scan SHALL produce no done pulse.
REQ-030 First cycle after rst deasserts SHALL evaluate IDLE transitions normally.

Configuration
REQ-031 Macro DECODER_ACTIVE_LOW_EN defined: y SHALL be bitwise-inverted (inactive = all ones, reset value all ones, one-cold); FSM, idx, busy, done unchanged.
REQ-032 Macro DECODER_ACTIVE_LOW_EN undefined: y active-high one-hot as above, reset value 0.

Verification (M=2, DWELL=4 unless noted)
REQ-033 Direct: en=1, mode=0, a=00,01,10,11 each held 5 cycles -> y=0001,0010,0100,1000 one cycle after each a change; en=0 -> y=0000 next cycle.
REQ-034 Single scan: mode=1, a=01, start pulse, cont=0 -> y=0010 x4, 0100 x4, 1000 x4, then y=0000, done=1 one cycle, busy high 12 cycles.
REQ-035 Continuous: a=11, start, cont=1 -> y=1000 x4, 0001 x4, 0010 x4 ...; no done; clear cont -> ends after channel 3, done pulse.
REQ-036 Abort: stop asserted on same cycle as last dwell of channel 3 -> IDLE, y=0000, done stays 0; repeat with rst instead of stop -> same, idx=00.
REQ-037 DWELL=1, a=00, start -> y=0001,0010,0100,1000 on consecutive cycles, done on 5th cycle; start pulses mid-scan ignored.
REQ-038 Build with DECODER_ACTIVE_LOW_EN, repeat REQ-033 -> y=1110,1101,1011,0111; reset and en=0 -> y=1111.
